// File: rtl/lsc_i2cs.sv
// lsc_i2cs: I2C target (slave) with a single-cycle register port.
//
// Matches a 7-bit device address, takes an 8-bit register offset, then
// writes incoming bytes to or reads outgoing bytes from the register port.
// SCL/SDA are synchronised and stability-filtered before any decoding.
// No clock stretching. SCL low time must be at least FILT_LEN+4 clk.
//
// Parameters:
//   DEV_ADDR   7-bit device address this target answers to
//   FILT_LEN   clk cycles a new input level must hold before it is accepted (1..15)
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   scl_in     SCL pad input (asynchronous)
//   sda_in     SDA pad input (asynchronous)
//   sda_out    SDA open-drain drive: 0 pulls low, 1 releases
//   reg_addr   register offset for the current access
//   reg_wdata  write data, valid while reg_we=1
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe; reg_rdata is taken on the following cycle
//   reg_rdata  read data from the register bank
//   busy       addressed and active (cleared by STOP or by going to WAIT)
//   stop_det   one-cycle pulse on every STOP seen on the bus
//
// Build option:
//   I2CS_AUTOINC_EN  when defined, reg_addr walks consecutive offsets in bursts;
//                    otherwise it stays at the received offset.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus idle, waiting for START
// DADDR    | shifting in device address + R/W bit
// DACK     | driving ACK for the device address
// OFS      | shifting in register offset
// OACK     | driving ACK for the offset
// WDATA    | shifting in a write data byte
// WACK     | driving ACK for a write data byte
// RDATA    | shifting out a read data byte
// RACK     | SDA released, sampling the master ACK/NACK
// WAIT     | not addressed or read ended; ignore bus until START/STOP

module lsc_i2cs #(
    parameter logic [6:0] DEV_ADDR = 7'h24,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       stop_det
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DADDR, ST_DACK, ST_OFS, ST_OACK,
        ST_WDATA, ST_WACK, ST_RDATA, ST_RACK, ST_WAIT
    } state_t;

    localparam logic [3:0] FILT_TC = 4'(FILT_LEN - 1);

    // Index 0 carries SCL, index 1 carries SDA through the conditioning path.
    logic [1:0]      s1_q, s1_d, s2_q, s2_d, flt_q, flt_d, prev_q, prev_d;
    logic [1:0][3:0] cnt_q, cnt_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] sh_q, sh_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       ack_rise_q, ack_rise_d;
    logic       sda_out_q, sda_out_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       re_dly_q, re_dly_d;
    logic       busy_q, busy_d;
    logic       stop_det_q, stop_det_d;

    logic       scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c, last_bit;
    logic [7:0] sh_next;

    // Synchroniser and stability filter; the down-counter reloads whenever
    // the synchronised input agrees with the filtered level.
    always_comb begin
        s1_d   = {sda_in, scl_in};
        s2_d   = s1_q;
        prev_d = flt_q;
        for (int i = 0; i < 2; i++) begin
            flt_d[i] = flt_q[i];
            cnt_d[i] = FILT_TC;
            if (s2_q[i] != flt_q[i]) begin
                if (cnt_q[i] == 4'd0) flt_d[i] = s2_q[i];
                else                  cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end
    end

    assign scl_f    = flt_q[0];
    assign sda_f    = flt_q[1];
    assign scl_rise = scl_f & ~prev_q[0];
    assign scl_fall = ~scl_f & prev_q[0];
    assign start_c  = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
    assign stop_c   = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
    assign sh_next  = {sh_q, sda_f};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ack_rise_d  = ack_rise_q;
        sda_out_d   = sda_out_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        re_dly_d    = reg_re_q;
        busy_d      = busy_q;
        stop_det_d  = 1'b0;

        // Read data arrives the cycle after the strobe.
        if (re_dly_q) tx_d = reg_rdata;
`ifdef I2CS_AUTOINC_EN
        if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;
`endif

        if (stop_c) begin
            state_d    = ST_IDLE;
            sda_out_d  = 1'b1;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (start_c) begin
            state_d    = ST_DADDR;
            bit_cnt_d  = 3'd0;
            sda_out_d  = 1'b1;
            ack_rise_d = 1'b0;
        end else begin
            case (state_q)
                ST_DADDR, ST_OFS, ST_WDATA: begin
                    if (scl_rise) begin
                        sh_d       = sh_next[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        ack_rise_d = 1'b0;
                        if (last_bit) begin
                            case (state_q)
                                ST_DADDR: begin
                                    // sh_q holds the 7 address bits, the current bit is R/W.
                                    if (sh_q == DEV_ADDR) begin
                                        state_d = ST_DACK;
                                        busy_d  = 1'b1;
                                        rw_d    = sda_f;
                                    end else begin
                                        state_d = ST_WAIT;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_OFS: begin
                                    state_d    = ST_OACK;
                                    reg_addr_d = sh_next;
                                end
                                default: begin
                                    state_d     = ST_WACK;
                                    reg_wdata_d = sh_next;
                                    reg_we_d    = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                // ACK bit: first fall pulls SDA low, the rise marks the ACK
                // clock, the second fall hands the bus on to the next byte.
                ST_DACK, ST_OACK, ST_WACK: begin
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                        if (state_q == ST_DACK && rw_q) reg_re_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            sda_out_d = 1'b0;
                        end else begin
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            if (state_q == ST_DACK && rw_q) begin
                                state_d   = ST_RDATA;
                                sda_out_d = tx_q[7];
                                tx_d      = {tx_q[6:0], 1'b0};
                            end else begin
                                state_d   = (state_q == ST_DACK) ? ST_OFS : ST_WDATA;
                                sda_out_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            state_d    = ST_RACK;
                            ack_rise_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_out_d = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            ack_rise_d = 1'b1;
                            reg_re_d   = 1'b1;
`ifdef I2CS_AUTOINC_EN
                            reg_addr_d = reg_addr_q + 8'd1;
`endif
                        end else begin
                            state_d   = ST_WAIT;
                            busy_d    = 1'b0;
                            sda_out_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            sda_out_d = 1'b1;
                        end else begin
                            state_d    = ST_RDATA;
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            sda_out_d  = tx_q[7];
                            tx_d       = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= 2'b11;
            s2_q        <= 2'b11;
            flt_q       <= 2'b11;
            prev_q      <= 2'b11;
            cnt_q       <= {FILT_TC, FILT_TC};
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            sh_q        <= 7'd0;
            tx_q        <= 8'd0;
            rw_q        <= 1'b0;
            ack_rise_q  <= 1'b0;
            sda_out_q   <= 1'b1;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            re_dly_q    <= 1'b0;
            busy_q      <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            flt_q       <= flt_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ack_rise_q  <= ack_rise_d;
            sda_out_q   <= sda_out_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            re_dly_q    <= re_dly_d;
            busy_q      <= busy_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign sda_out   = sda_out_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_lsc_i2cs.sv
// Testbench for lsc_i2cs: bit-banged I2C master on a wired-AND SDA line,
// a small register memory behind the register port, and strobe recorders.
module tb_lsc_i2cs;

    localparam int HP = 12;  // SCL half period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_out;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy, stop_det;
    logic [7:0] rdata_r = 8'h00;

    always #5 clk = ~clk;

    assign sda_line  = sda_m & sda_out;
    assign reg_rdata = rdata_r;

    lsc_i2cs #(.DEV_ADDR(7'h24), .FILT_LEN(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_out  (sda_out),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .stop_det (stop_det)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    logic [7:0] we_addr [64];
    logic [7:0] we_data [64];
    logic [7:0] re_addr [64];
    int we_cnt = 0, re_cnt = 0, stop_cnt = 0;

    always @(negedge clk) begin
        if (reg_we === 1'b1 && we_cnt < 64) begin
            we_addr[we_cnt] = reg_addr;
            we_data[we_cnt] = reg_wdata;
            mem[reg_addr]   = reg_wdata;
            we_cnt++;
        end
        if (reg_re === 1'b1 && re_cnt < 64) begin
            re_addr[re_cnt] = reg_addr;
            rdata_r         = mem[reg_addr];
            re_cnt++;
        end
        if (stop_det === 1'b1) stop_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Handles both a fresh START (bus idle) and a repeated START (SCL low).
    task automatic i2c_start;
        if (scl_m == 1'b0) begin
            clks(HP / 2); sda_m = 1'b1; clks(HP / 2); scl_m = 1'b1;
        end
        sda_m = 1'b1; clks(HP);
        sda_m = 1'b0; clks(HP);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        clks(HP / 2); sda_m = 1'b0; clks(HP / 2);
        scl_m = 1'b1; clks(HP);
        sda_m = 1'b1; clks(2 * HP);
    endtask

    task automatic put_bit(input logic b);
        clks(HP / 2); sda_m = b; clks(HP / 2);
        scl_m = 1'b1; clks(HP);
        scl_m = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        clks(HP / 2); sda_m = 1'b1; clks(HP / 2);
        scl_m = 1'b1; clks(HP - 1);
        b = sda_line; clks(1);
        scl_m = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic master_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~master_ack);
    endtask

    // dat/adr pack byte k at bits [8k+7:8k].
    typedef struct packed {
        logic [7:0]  dev;
        logic [7:0]  ofs;
        logic [1:0]  n;
        logic [23:0] dat;
        logic        dev_ack;
        logic [23:0] adr;
    } wvec_t;

    task automatic run_wvec(input wvec_t v);
        int   we0, st0, exp_we;
        logic a;
        we0 = we_cnt; st0 = stop_cnt;
        exp_we = v.dev_ack ? int'(v.n) : 0;
        i2c_start;
        put_byte(v.dev, a);
        chk("dev_ack", 32'(a), 32'(v.dev_ack));
        clks(2);
        chk("busy_after_addr", 32'(busy), 32'(v.dev_ack));
        if (a) begin
            put_byte(v.ofs, a);
            chk("ofs_ack", 32'(a), 32'd1);
            for (int k = 0; k < int'(v.n); k++) begin
                put_byte(v.dat[k*8 +: 8], a);
                chk("data_ack", 32'(a), 32'd1);
            end
        end
        i2c_stop;
        chk("we_count", 32'(we_cnt - we0), 32'(exp_we));
        for (int k = 0; k < exp_we; k++) begin
            chk("we_addr", 32'(we_addr[we0 + k]), 32'(v.adr[k*8 +: 8]));
            chk("we_data", 32'(we_data[we0 + k]), 32'(v.dat[k*8 +: 8]));
        end
        chk("stop_det_count", 32'(stop_cnt - st0), 32'd1);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("sda_released", 32'(sda_out), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wvec_t      vec [4];
        wvec_t      tail;
        logic       a;
        logic [7:0] d0, d1;
        int         we0, re0, st0;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vec[0] = '{dev: 8'h48, ofs: 8'h10, n: 2'd1, dat: 24'h00005A, dev_ack: 1'b1, adr: 24'h000010};
        vec[1] = '{dev: 8'h30, ofs: 8'h10, n: 2'd1, dat: 24'h000077, dev_ack: 1'b0, adr: 24'h000000};
`ifdef I2CS_AUTOINC_EN
        vec[2] = '{dev: 8'h48, ofs: 8'hFE, n: 2'd3, dat: 24'h332211, dev_ack: 1'b1, adr: 24'h00FFFE};
        vec[3] = '{dev: 8'h48, ofs: 8'h05, n: 2'd2, dat: 24'h003CA5, dev_ack: 1'b1, adr: 24'h000605};
`else
        vec[2] = '{dev: 8'h48, ofs: 8'hFE, n: 2'd3, dat: 24'h332211, dev_ack: 1'b1, adr: 24'hFEFEFE};
        vec[3] = '{dev: 8'h48, ofs: 8'h05, n: 2'd2, dat: 24'h003CA5, dev_ack: 1'b1, adr: 24'h000505};
`endif

        // Reset state
        reset = 1'b1;
        clks(4);
        chk("rst_sda_out",   32'(sda_out),   32'd1);
        chk("rst_reg_we",    32'(reg_we),    32'd0);
        chk("rst_reg_re",    32'(reg_re),    32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_stop_det",  32'(stop_det),  32'd0);
        chk("rst_reg_addr",  32'(reg_addr),  32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        reset = 1'b0;
        clks(4);

        // Writes: single, address mismatch, bursts
        for (int i = 0; i < 4; i++) run_wvec(vec[i]);

        // Single read via write-offset / repeated START / read
        mem[8'h10] = 8'hC3;
        we0 = we_cnt; re0 = re_cnt; st0 = stop_cnt;
        i2c_start;
        put_byte(8'h48, a); chk("rd_dev_w_ack", 32'(a), 32'd1);
        put_byte(8'h10, a); chk("rd_ofs_ack", 32'(a), 32'd1);
        i2c_start;
        put_byte(8'h49, a); chk("rd_dev_r_ack", 32'(a), 32'd1);
        chk("rd_busy", 32'(busy), 32'd1);
        get_byte(d0, 1'b0);
        i2c_stop;
        chk("rd_data", 32'(d0), 32'hC3);
        chk("rd_re_count", 32'(re_cnt - re0), 32'd1);
        chk("rd_re_addr", 32'(re_addr[re0]), 32'h10);
        chk("rd_we_count", 32'(we_cnt - we0), 32'd0);
        chk("rd_stop_count", 32'(stop_cnt - st0), 32'd1);
        chk("rd_busy_end", 32'(busy), 32'd0);

        // Two-byte read burst from 0x20
        mem[8'h20] = 8'h9E;
        mem[8'h21] = 8'h47;
        re0 = re_cnt;
        i2c_start;
        put_byte(8'h48, a);
        put_byte(8'h20, a);
        i2c_start;
        put_byte(8'h49, a); chk("brd_dev_ack", 32'(a), 32'd1);
        get_byte(d0, 1'b1);
        get_byte(d1, 1'b0);
        i2c_stop;
        chk("brd_data0", 32'(d0), 32'h9E);
        chk("brd_re_count", 32'(re_cnt - re0), 32'd2);
        chk("brd_re_addr0", 32'(re_addr[re0]), 32'h20);
`ifdef I2CS_AUTOINC_EN
        chk("brd_data1", 32'(d1), 32'h47);
        chk("brd_re_addr1", 32'(re_addr[re0 + 1]), 32'h21);
`else
        chk("brd_data1", 32'(d1), 32'h9E);
        chk("brd_re_addr1", 32'(re_addr[re0 + 1]), 32'h20);
`endif

        // STOP after 4 data bits
        we0 = we_cnt; st0 = stop_cnt;
        i2c_start;
        put_byte(8'h48, a);
        put_byte(8'h10, a);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        i2c_stop;
        chk("pstop_we_count", 32'(we_cnt - we0), 32'd0);
        chk("pstop_stop_count", 32'(stop_cnt - st0), 32'd1);
        chk("pstop_sda", 32'(sda_out), 32'd1);
        chk("pstop_busy", 32'(busy), 32'd0);

        // 1-clk glitches on SCL (low phase) and SDA (high phase) in byte 0x81
        we0 = we_cnt; st0 = stop_cnt;
        i2c_start;
        put_byte(8'h48, a);
        put_byte(8'h30, a);
        clks(HP / 2); sda_m = 1'b1; clks(2);
        scl_m = 1'b1; clks(1); scl_m = 1'b0; clks(HP / 2 - 3);
        scl_m = 1'b1; clks(HP / 2);
        sda_m = 1'b0; clks(1); sda_m = 1'b1; clks(HP / 2 - 1);
        scl_m = 1'b0;
        clks(HP / 2); sda_m = 1'b0; clks(HP / 2);
        scl_m = 1'b1; clks(HP / 2);
        sda_m = 1'b1; clks(1); sda_m = 1'b0; clks(HP / 2 - 1);
        scl_m = 1'b0;
        for (int i = 5; i >= 0; i--) put_bit(i == 0);
        get_bit(a);
        chk("glitch_ack", 32'(a), 32'd0);
        chk("glitch_no_stop", 32'(stop_cnt - st0), 32'd0);
        i2c_stop;
        chk("glitch_we_count", 32'(we_cnt - we0), 32'd1);
        chk("glitch_we_addr", 32'(we_addr[we0]), 32'h30);
        chk("glitch_we_data", 32'(we_data[we0]), 32'h81);

        // Reset while driving a 0 data bit in RDATA
        mem[8'h40] = 8'h00;
        i2c_start;
        put_byte(8'h48, a);
        put_byte(8'h40, a);
        i2c_start;
        put_byte(8'h49, a);
        get_bit(a); get_bit(a); get_bit(a);
        clks(HP / 2 + 2);
        chk("rst_rd_driving", 32'(sda_out), 32'd0);
        reset = 1'b1;
        clks(1);
        chk("rst_rd_sda_release", 32'(sda_out), 32'd1);
        chk("rst_rd_busy", 32'(busy), 32'd0);
        clks(1);
        reset = 1'b0;
        clks(2 * HP);
        st0 = stop_cnt;
        i2c_stop;
        chk("rst_rd_stop_count", 32'(stop_cnt - st0), 32'd1);

        // Target re-syncs at the next START
        tail = '{dev: 8'h48, ofs: 8'h07, n: 2'd1, dat: 24'h0000E1, dev_ack: 1'b1, adr: 24'h000007};
        run_wvec(tail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
